// File: rtl/gshare_pht_if.sv
// Gshare PHT port bundle: predict request/response, EX-side training and status.
// Latency: n/a (signal bundle only).
// Backpressure: none; stall is a plain level that freezes the predict-side response.
//
// master: the front end / GHR side that drives lookups and training.
// slave : the pattern history table itself.
interface gshare_pht_if #(
  parameter int GH_W = 32,
  parameter int PC_W = 32
);
  // predict side
  logic            stall;
  logic [PC_W-1:0] pc_pdc;
  logic [GH_W-1:0] gh;
  logic            taken_pdc;
  logic [1:0]      ctr_pdc;
  // update side
  logic            update_en;
  logic            is_jump_ex;
  logic [PC_W-1:0] pc_ex;
  logic [GH_W-1:0] gh_ex;
  logic            taken_ex;
  logic            mis_pdc;
  // status
  logic            init_busy;
  logic [31:0]     mis_cnt;

  modport master (
    output stall, pc_pdc, gh, update_en, is_jump_ex, pc_ex, gh_ex, taken_ex, mis_pdc,
    input  taken_pdc, ctr_pdc, init_busy, mis_cnt
  );

  modport slave (
    input  stall, pc_pdc, gh, update_en, is_jump_ex, pc_ex, gh_ex, taken_ex, mis_pdc,
    output taken_pdc, ctr_pdc, init_busy, mis_cnt
  );
endinterface

// File: rtl/gshare_pht.sv
// Gshare pattern history table of 2^IDX_W 2-bit saturating counters with init sweep.
// Latency: prediction is combinational (0 cycles); a trained value is readable next cycle.
// Backpressure: none; stall freezes the predict outputs, training is never blocked.
//
// Ports: clk, rstn (async active-low); bus (gshare_pht_if.slave) carries
//   predict  : stall, pc_pdc, gh -> taken_pdc, ctr_pdc
//   training : update_en, is_jump_ex, pc_ex, gh_ex, taken_ex, mis_pdc
//   status   : init_busy (sweep running), mis_cnt (saturating mispredict count)
// Optional feature: define PHT_BYPASS_EN to forward a same-cycle update on the
// predicted index into taken_pdc/ctr_pdc.
module gshare_pht #(
  parameter int         IDX_W    = 10,
  parameter int         GH_W     = 32,
  parameter int         PC_W     = 32,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input logic         clk,
  input logic         rstn,
  gshare_pht_if.slave bus
);

  localparam int TBL_N = 1 << IDX_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_ptr;
  logic             init_busy;
  logic [31:0]      mis_cnt;

  logic [1:0]       pht [TBL_N];

  logic [IDX_W-1:0] idx_p;
  logic [IDX_W-1:0] idx_u;
  logic             upd_qual;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_new;
  logic [1:0]       ctr_rd;
  logic [1:0]       ctr_live;
  logic [1:0]       ctr_hold;
  logic [1:0]       ctr_out;

  // PC bits [1:0] are the instruction alignment and carry no branch identity.
  assign idx_p = bus.pc_pdc[IDX_W+1:2] ^ bus.gh[IDX_W-1:0];
  assign idx_u = bus.pc_ex[IDX_W+1:2]  ^ bus.gh_ex[IDX_W-1:0];

  // Training is dropped entirely while the sweep owns the write port.
  assign upd_qual = bus.update_en & bus.is_jump_ex & (state == S_RUN);

  assign ctr_cur = pht[idx_u];

  always_comb begin
    ctr_new = ctr_cur;
    if (bus.taken_ex) begin
      if (ctr_cur != 2'b11) ctr_new = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_new = ctr_cur - 2'd1;
    end
  end

  // Single write port: the sweep has priority and only runs in INIT, so it
  // never competes with training. No reset: contents are rebuilt by the sweep.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      pht[sweep_ptr] <= INIT_CTR;
    end else if (upd_qual) begin
      pht[idx_u] <= ctr_new;
    end
  end

  // Init sweep FSM plus the mispredict counter; init_busy is registered
  // alongside the state so it drops on the same edge as the move to RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_INIT;
      sweep_ptr <= '0;
      init_busy <= 1'b1;
      mis_cnt   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == {IDX_W{1'b1}}) begin
            state     <= S_RUN;
            init_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (upd_qual && bus.mis_pdc && (mis_cnt != 32'hFFFF_FFFF)) begin
            mis_cnt <= mis_cnt + 32'd1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Prediction read. With forwarding, a same-cycle qualified update on the
  // looked-up entry is shown immediately instead of the stored value.
`ifdef PHT_BYPASS_EN
  assign ctr_rd = (upd_qual && (idx_u == idx_p)) ? ctr_new : pht[idx_p];
`else
  assign ctr_rd = pht[idx_p];
`endif

  // Table contents are meaningless until the sweep finishes, so mask to 0.
  assign ctr_live = init_busy ? 2'b00 : ctr_rd;

  // Captures the live response every non-stalled cycle; while stalled the
  // front end keeps seeing the response it already acted on.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctr_hold <= 2'b00;
    end else if (!bus.stall) begin
      ctr_hold <= ctr_live;
    end
  end

  assign ctr_out       = bus.stall ? ctr_hold : ctr_live;
  assign bus.ctr_pdc   = ctr_out;
  assign bus.taken_pdc = ctr_out[1];
  assign bus.init_busy = init_busy;
  assign bus.mis_cnt   = mis_cnt;

  // Bits outside the index window are intentionally not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_pdc[PC_W-1:IDX_W+2], bus.pc_pdc[1:0],
                            bus.pc_ex[PC_W-1:IDX_W+2], bus.pc_ex[1:0]};

  generate
    if (GH_W > IDX_W) begin : g_gh_hi
      logic unused_gh_bits;
      assign unused_gh_bits = ^{bus.gh[GH_W-1:IDX_W], bus.gh_ex[GH_W-1:IDX_W]};
    end
  endgenerate

endmodule
